// File: rtl/rx_sequencer.sv
// rx_sequencer: oversampling asynchronous serial receiver with a one-deep holding register.
// Define RX_PARITY_CHECK_EN to add an even-parity bit between the data bits and the stop bit.
module rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    output logic       shift,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef RX_PARITY_CHECK_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // Line synchronizer plus one extra flop for falling-edge detection.
    logic sync_reg;
    logic rxs_reg;
    logic rxs_prev_reg;
    logic fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg     <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= rxd;
            rxs_reg      <= sync_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    assign fall = rxs_prev_reg & ~rxs_reg;

    logic [2:0]           state_reg, state_next;
    logic [TICK_W-1:0]    tick_reg, tick_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] sr_reg, sr_next;
    logic                 shift_reg, shift_next;
    logic                 frame_done;
    logic [DATA_BITS-1:0] sr_shifted;
    logic [7:0]           sr_ext;
    logic                 perr;

    // LSB-first: each new sample enters at the top and the word moves down.
    generate
        for (genvar gi = 0; gi < DATA_BITS - 1; gi++) begin : g_sr
            assign sr_shifted[gi] = sr_reg[gi+1];
        end
    endgenerate
    assign sr_shifted[DATA_BITS-1] = rxs_reg;

    always_comb begin
        sr_ext = 8'd0;
        sr_ext[DATA_BITS-1:0] = sr_reg;
    end

`ifdef RX_PARITY_CHECK_EN
    logic par_reg, par_next;
    assign perr = ^{sr_reg, par_reg};
`else
    assign perr = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        idx_next   = idx_reg;
        sr_next    = sr_reg;
        shift_next = 1'b0;
        frame_done = 1'b0;
`ifdef RX_PARITY_CHECK_EN
        par_next   = par_reg;
`endif
        if (!enable) begin
            state_next = S_IDLE;
            tick_next  = '0;
            idx_next   = '0;
            sr_next    = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    tick_next = '0;
                    if (fall) begin
                        state_next = S_START;
                    end
                end
                S_START: begin
                    if (tick_reg == TICK_HALF) begin
                        tick_next  = '0;
                        idx_next   = '0;
                        state_next = rxs_reg ? S_IDLE : S_DATA;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        sr_next    = sr_shifted;
                        shift_next = 1'b1;
                        if (idx_reg == IDX_LAST) begin
                            idx_next = '0;
`ifdef RX_PARITY_CHECK_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
`ifdef RX_PARITY_CHECK_EN
                S_PARITY: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        par_next   = rxs_reg;
                        state_next = S_STOP;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        frame_done = 1'b1;
                        // A start edge coinciding with completion must not be lost.
                        state_next = fall ? S_START : S_IDLE;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    tick_next  = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            tick_reg  <= '0;
            idx_reg   <= '0;
            sr_reg    <= '0;
            shift_reg <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            idx_reg   <= idx_next;
            sr_reg    <= sr_next;
            shift_reg <= shift_next;
`ifdef RX_PARITY_CHECK_EN
            par_reg   <= par_next;
`endif
        end
    end

    logic [7:0] data_reg;
    logic       valid_reg;
    logic       frame_err_reg;
    logic       overrun_reg;
    logic       parity_err_reg;

    // Holding register: a completed frame loads only if the previous one is gone or leaving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg       <= 8'd0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (frame_done && (!valid_reg || ack)) begin
                data_reg       <= sr_ext;
                valid_reg      <= 1'b1;
                frame_err_reg  <= ~rxs_reg;
                parity_err_reg <= perr;
            end else if (valid_reg && ack) begin
                valid_reg <= 1'b0;
            end

            if (frame_done && valid_reg && !ack) begin
                overrun_reg <= 1'b1;
            end else if (valid_reg && ack) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign shift      = shift_reg;
    assign data       = data_reg;
    assign valid      = valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
`ifdef RX_PARITY_CHECK_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer: frames are driven on rxd, expected characters queued,
// and a negedge monitor compares every character the receiver presents.
module tb_rx_sequencer;

    localparam int OS = 16;
    localparam int DB = 8;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic       shift;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rxd        (rxd),
        .shift      (shift),
        .data       (data),
        .valid      (valid),
        .ack        (ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   shift_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic valid_seen = 1'b0;
    exp_t mon_e;
`ifdef RX_PARITY_CHECK_EN
    logic par_flip = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic ferr, input logic perr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (OS) @(negedge clk);
        end
`ifdef RX_PARITY_CHECK_EN
        rxd = (^d) ^ par_flip;
        repeat (OS) @(negedge clk);
`endif
        rxd = stop_bit;
        repeat (OS) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Monitor: each rising valid is one presented character.
    always @(negedge clk) begin
        if (shift) shift_q.push_back(cyc);
        if (valid && !valid_seen) begin
            check("output_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                $display("rx char data=%02h frame_err=%0d parity_err=%0d overrun=%0d",
                         data, frame_err, parity_err, overrun);
                check("rx_data", 32'(data), 32'(mon_e.data));
                check("rx_frame_err", 32'(frame_err), 32'(mon_e.ferr));
                check("rx_parity_err", 32'(parity_err), 32'(mon_e.perr));
            end
        end
        valid_seen = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        rxd = 1'b1;
        ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_data", 32'(data), 0);
        check("reset_shift", 32'(shift), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_parity_err", 32'(parity_err), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with shift pulse spacing
        shift_q.delete();
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1);
        check("a5_shift_count", shift_q.size(), 8);
        if (shift_q.size() == 8) begin
            for (int i = 1; i < 8; i++) check("a5_shift_gap", shift_q[i] - shift_q[i-1], OS);
        end
        do_ack();
        check("a5_ack_valid", 32'(valid), 0);

        // False start
        shift_q.delete();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("false_start_shift", shift_q.size(), 0);
        check("false_start_valid", 32'(valid), 0);
        check("false_start_busy", 32'(busy), 0);

        // Framing error
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        do_ack();
        check("3c_ack_valid", 32'(valid), 0);

        // Ack without valid is ignored
        do_ack();
        check("idle_ack_valid", 32'(valid), 0);
        check("idle_ack_overrun", 32'(overrun), 0);

        // Back-to-back frames without ack: overrun
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_data", 32'(data), 32'h11);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_flag", 32'(overrun), 1);
        do_ack();
        check("ovr_ack_valid", 32'(valid), 0);
        check("ovr_ack_flag", 32'(overrun), 0);
        check("ovr_ack_data_held", 32'(data), 32'h11);

        // Reset during data bit 4
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(negedge clk);
                check("midframe_busy", 32'(busy), 1);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                check("midreset_busy", 32'(busy), 0);
                check("midreset_data", 32'(data), 0);
                rst = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        push_exp(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1);
        do_ack();

        // Enable dropped mid-frame: receiver idles, holding register kept
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (40) @(negedge clk);
                check("en_busy_before", 32'(busy), 1);
                enable = 1'b0;
                repeat (2) @(negedge clk);
                check("en_busy_after", 32'(busy), 0);
                check("en_data_held", 32'(data), 32'h0F);
            end
        join
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("en_no_valid", 32'(valid), 0);

`ifdef RX_PARITY_CHECK_EN
        par_flip = 1'b1;
        push_exp(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b1);
        do_ack();
        par_flip = 1'b0;
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1);
        do_ack();
`endif

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
